toy_multi_ctrl: RTL and testbench
=================================

Name: toy_multi_ctrl

Overview:
- Multi-cycle control FSM for the TOY processor.
- Sits directly upstream of the datapath storage registers (PC, IR, A, B, result) and the register file, and drives their write enables.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Handshakes with memory via mem_ready; counts retired instructions.

Parameters:
- DATA_W, 16, instruction/data width; opcode is ir[DATA_W-1:DATA_W-4].
- PC_W, 12, program counter width; branch target is ir[7:0] zero-extended to PC_W.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ir  in  DATA_W  current instruction from the IR register.
- a_zero  in  1  operand A == 0.
- a_pos  in  1  operand A > 0 (sign bit clear and nonzero).
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_wr, ir_wr, a_wr, b_wr, res_wr, rf_wr  out  1 each  register write enables.
- mem_rd, mem_wr  out  1  memory request strobes.
- addr_sel  out  1  0 = PC addresses memory, 1 = data address (ir[7:0] or reg, per opcode).
- pc_src  out  2  0 = PC+1, 1 = ir[7:0], 2 = register A.
- rf_wsel  out  2  0 = ALU result, 1 = memory data, 2 = immediate ir[7:0], 3 = PC.
- alu_op  out  3  ALU operation: 0 add, 1 sub, 2 and, 3 xor, 4 shl, 5 shr.
- halted  out  1  FSM parked in HALT.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- State register: reset low → FETCH asynchronously; instr_count=0, halted=0.
- All enables and strobes are forced 0 while reset is low. Otherwise they are combinational from state, opcode and mem_ready.
- Multi-bit selects default to 0 when not in use.
- FETCH:
  - mem_rd=1, addr_sel=0.
  - Stays in FETCH while mem_ready=0, with no write enables.
  - On mem_ready=1: ir_wr=1, pc_wr=1, pc_src=0, then → DECODE.
- DECODE:
  - a_wr=1, b_wr=1.
  - Opcode 0 → HALT; any other opcode → EXEC.
- EXEC:
  - Opcodes 1-6: res_wr=1, alu_op=opcode-1 → WB.
  - Opcode 7: → WB; WB uses rf_wsel=2.
  - Opcodes 8, 9, A, B: → MEM.
  - Opcode C: if a_zero, pc_wr=1 and pc_src=1. → FETCH in either case.
  - Opcode D: same as C, gated by a_pos.
  - Opcode E: pc_wr=1, pc_src=2 → FETCH.
  - Opcode F: rf_wr=1, rf_wsel=3 (PC already incremented), pc_wr=1, pc_src=1 → FETCH.
- MEM:
  - addr_sel=1.
  - Opcodes 8 and A: mem_rd=1; on mem_ready → WB with rf_wsel=1.
  - Opcodes 9 and B: mem_wr=1; on mem_ready → FETCH.
  - Strobe is held until mem_ready; unbounded wait.
- WB: rf_wr=1 with rf_wsel per opcode (1-6 → 0, 7 → 2, 8/A → 1) → FETCH.
- HALT:
  - halted=1, all enables 0, absorbing.
  - Exit only by reset.
- instr_count:
  - +1 on every transition into FETCH from EXEC, MEM or WB, and on entry to HALT.
  - Wraps modulo 2^CNT_W.
- Latency in cycles, with mem_ready immediate:
  - ALU op or opcode 7: 4.
  - Load: 5.
  - Store: 4.
  - Branch, jump or jump-and-link: 3.
- mem_ready outside FETCH/MEM is ignored.
- The IR is stable from DECODE onward; the FSM does not re-sample opcode-dependent decisions from memory.
- Reset low mid-instruction: enables drop immediately, state → FETCH, no partial write is issued, instr_count → 0.

Test Plan:
- Reset low 3 cycles, release with mem_ready=1, ir=0x1123 → FETCH, DECODE, EXEC, WB sequence. EXEC has res_wr=1, alu_op=0. WB has rf_wr=1, rf_wsel=0. instr_count=1 on return to FETCH.
- ir=0x8A10, mem_ready low for 3 cycles in MEM → mem_rd=1, addr_sel=1 held 3 cycles, no rf_wr. Then WB has rf_wr=1, rf_wsel=1.
- ir=0xC105: a_zero=1 → pc_wr=1, pc_src=1 in EXEC. Repeat with a_zero=0 → pc_wr=0. Both return to FETCH after 3 cycles.
- ir=0xF240 → EXEC asserts rf_wr, rf_wsel=3, pc_wr, pc_src=1 in one cycle.
- ir=0x0000 → HALT, halted=1, all enables 0 for 20 cycles. Reset clears halted and instr_count.
- Preload instr_count to 0xFFFF via 65535 opcode-C instructions, then one more → 0x0000. Assert reset mid-MEM on a store → mem_wr drops the same cycle, state FETCH.

Source files
------------

// File: rtl/toy_multi_ctrl.sv
// Multi-cycle control FSM for the TOY processor: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives datapath write enables and memory strobes, and counts retired instructions.
module toy_multi_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PC_W   = 12,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] ir_i,
  input  logic              a_zero_i,
  input  logic              a_pos_i,
  input  logic              mem_ready_i,
  output logic              pc_wr_o,
  output logic              ir_wr_o,
  output logic              a_wr_o,
  output logic              b_wr_o,
  output logic              res_wr_o,
  output logic              rf_wr_o,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  output logic              addr_sel_o,
  output logic [1:0]        pc_src_o,
  output logic [1:0]        rf_wsel_o,
  output logic [2:0]        alu_op_o,
  output logic              halted_o,
  output logic [CNT_W-1:0]  instr_count_o
);

  // The PC datapath lives outside this block; its width does not shape any control decision.
  localparam int unsigned unused_pc_w = PC_W;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic [3:0]       opcode;
  logic             unused_ir;

  assign opcode    = ir_i[DATA_W-1:DATA_W-4];
  assign unused_ir = ^ir_i[DATA_W-5:0];

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    pc_wr_o    = 1'b0;
    ir_wr_o    = 1'b0;
    a_wr_o     = 1'b0;
    b_wr_o     = 1'b0;
    res_wr_o   = 1'b0;
    rf_wr_o    = 1'b0;
    mem_rd_o   = 1'b0;
    mem_wr_o   = 1'b0;
    addr_sel_o = 1'b0;
    pc_src_o   = 2'd0;
    rf_wsel_o  = 2'd0;
    alu_op_o   = 3'd0;
    halted_o   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd_o = 1'b1;
        if (mem_ready_i) begin
          ir_wr_o = 1'b1;
          pc_wr_o = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_wr_o = 1'b1;
        b_wr_o = 1'b1;
        if (opcode == 4'h0) begin
          state_d = S_HALT;
          retire  = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
            res_wr_o = 1'b1;
            alu_op_o = opcode[2:0] - 3'd1;
            state_d  = S_WB;
          end
          4'h7:                   state_d = S_WB;
          4'h8, 4'h9, 4'hA, 4'hB: state_d = S_MEM;
          4'hC: begin
            pc_wr_o  = a_zero_i;
            pc_src_o = a_zero_i ? 2'd1 : 2'd0;
            retire   = 1'b1;
          end
          4'hD: begin
            pc_wr_o  = a_pos_i;
            pc_src_o = a_pos_i ? 2'd1 : 2'd0;
            retire   = 1'b1;
          end
          4'hE: begin
            pc_wr_o  = 1'b1;
            pc_src_o = 2'd2;
            retire   = 1'b1;
          end
          4'hF: begin
            // PC already holds the return address, so it is linked before the jump lands.
            rf_wr_o   = 1'b1;
            rf_wsel_o = 2'd3;
            pc_wr_o   = 1'b1;
            pc_src_o  = 2'd1;
            retire    = 1'b1;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        addr_sel_o = 1'b1;
        if (!opcode[0]) begin
          mem_rd_o = 1'b1;
          if (mem_ready_i) state_d = S_WB;
        end else begin
          mem_wr_o = 1'b1;
          if (mem_ready_i) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end
      end
      S_WB: begin
        rf_wr_o = 1'b1;
        if (opcode == 4'h7)      rf_wsel_o = 2'd2;
        else if (opcode[3])      rf_wsel_o = 2'd1;
        else                     rf_wsel_o = 2'd0;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:  halted_o = 1'b1;
      default: state_d  = S_FETCH;
    endcase
    // Reset must suppress every strobe immediately so no partial write escapes.
    if (!rst_ni) begin
      pc_wr_o    = 1'b0;
      ir_wr_o    = 1'b0;
      a_wr_o     = 1'b0;
      b_wr_o     = 1'b0;
      res_wr_o   = 1'b0;
      rf_wr_o    = 1'b0;
      mem_rd_o   = 1'b0;
      mem_wr_o   = 1'b0;
      addr_sel_o = 1'b0;
      pc_src_o   = 2'd0;
      rf_wsel_o  = 2'd0;
      alu_op_o   = 3'd0;
      halted_o   = 1'b0;
    end
  end

  assign cnt_d = retire ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_toy_multi_ctrl.sv
// Directed bench for toy_multi_ctrl: expected control vectors are queued per cycle and
// compared against the DUT outputs mid-cycle.
module tb_toy_multi_ctrl;
  localparam int DATA_W = 16;
  localparam int PC_W   = 12;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] ir;
  logic              a_zero, a_pos, mem_ready;
  logic              pc_wr, ir_wr, a_wr, b_wr, res_wr, rf_wr, mem_rd, mem_wr, addr_sel, halted;
  logic [1:0]        pc_src, rf_wsel;
  logic [2:0]        alu_op;
  logic [CNT_W-1:0]  instr_count;

  always #5 clk = ~clk;

  toy_multi_ctrl #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .ir_i(ir), .a_zero_i(a_zero), .a_pos_i(a_pos),
    .mem_ready_i(mem_ready), .pc_wr_o(pc_wr), .ir_wr_o(ir_wr), .a_wr_o(a_wr),
    .b_wr_o(b_wr), .res_wr_o(res_wr), .rf_wr_o(rf_wr), .mem_rd_o(mem_rd),
    .mem_wr_o(mem_wr), .addr_sel_o(addr_sel), .pc_src_o(pc_src), .rf_wsel_o(rf_wsel),
    .alu_op_o(alu_op), .halted_o(halted), .instr_count_o(instr_count)
  );

  typedef struct packed {
    logic       pc_wr, ir_wr, a_wr, b_wr, res_wr, rf_wr, mem_rd, mem_wr, addr_sel;
    logic [1:0] pc_src;
    logic [1:0] rf_wsel;
    logic [2:0] alu_op;
    logic       halted;
  } ctl_t;

  ctl_t obs;
  assign obs = {pc_wr, ir_wr, a_wr, b_wr, res_wr, rf_wr, mem_rd, mem_wr, addr_sel,
                pc_src, rf_wsel, alu_op, halted};

  ctl_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_errs   = 0;
  int    exp_cnt  = 0;

  function automatic ctl_t c_zero();
    ctl_t c = '0;
    return c;
  endfunction
  function automatic ctl_t c_fetch(input logic rdy);
    ctl_t c = '0;
    c.mem_rd = 1'b1;
    if (rdy) begin c.ir_wr = 1'b1; c.pc_wr = 1'b1; end
    return c;
  endfunction
  function automatic ctl_t c_decode();
    ctl_t c = '0;
    c.a_wr = 1'b1; c.b_wr = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_alu(input logic [2:0] op);
    ctl_t c = '0;
    c.res_wr = 1'b1; c.alu_op = op;
    return c;
  endfunction
  function automatic ctl_t c_wb(input logic [1:0] sel);
    ctl_t c = '0;
    c.rf_wr = 1'b1; c.rf_wsel = sel;
    return c;
  endfunction
  function automatic ctl_t c_mem(input logic load);
    ctl_t c = '0;
    c.addr_sel = 1'b1;
    if (load) c.mem_rd = 1'b1; else c.mem_wr = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_pc(input logic wr, input logic [1:0] src);
    ctl_t c = '0;
    c.pc_wr = wr; c.pc_src = src;
    return c;
  endfunction
  function automatic ctl_t c_jal();
    ctl_t c = '0;
    c.rf_wr = 1'b1; c.rf_wsel = 2'd3; c.pc_wr = 1'b1; c.pc_src = 2'd1;
    return c;
  endfunction
  function automatic ctl_t c_halt();
    ctl_t c = '0;
    c.halted = 1'b1;
    return c;
  endfunction

  task automatic check_ctl();
    ctl_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_checks++;
    assert (obs === e) else begin
      n_errs++;
      $error("FAIL %s: observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic step(input string tag, input ctl_t e, input logic rdy);
    mem_ready = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    check_ctl();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_cnt(input string tag);
    n_checks++;
    assert (instr_count === CNT_W'(exp_cnt)) else begin
      n_errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, instr_count, exp_cnt);
    end
  endtask

  task automatic retired();
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
  endtask

  initial begin
    rst_n = 1'b0; ir = '0; a_zero = 1'b0; a_pos = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    repeat (3) step("reset_idle", c_zero(), 1'b1);
    chk_cnt("reset_cnt");

    rst_n = 1'b1; ir = 16'h1123;
    step("add_fetch", c_fetch(1'b1), 1'b1);
    step("add_decode", c_decode(), 1'b1);
    step("add_exec", c_alu(3'd0), 1'b1);
    step("add_wb", c_wb(2'd0), 1'b1);
    retired(); chk_cnt("add_cnt");

    ir = 16'h8A10;
    step("ld_fetch_wait", c_fetch(1'b0), 1'b0);
    step("ld_fetch_wait", c_fetch(1'b0), 1'b0);
    step("ld_fetch", c_fetch(1'b1), 1'b1);
    step("ld_decode", c_decode(), 1'b1);
    step("ld_exec", c_zero(), 1'b1);
    repeat (3) step("ld_mem_wait", c_mem(1'b1), 1'b0);
    step("ld_mem_done", c_mem(1'b1), 1'b1);
    step("ld_wb", c_wb(2'd1), 1'b1);
    retired(); chk_cnt("ld_cnt");

    ir = 16'hC105; a_zero = 1'b1;
    step("bz_t_fetch", c_fetch(1'b1), 1'b1);
    step("bz_t_decode", c_decode(), 1'b1);
    step("bz_t_exec", c_pc(1'b1, 2'd1), 1'b1);
    retired(); chk_cnt("bz_t_cnt");
    a_zero = 1'b0;
    step("bz_n_fetch", c_fetch(1'b1), 1'b1);
    step("bz_n_decode", c_decode(), 1'b1);
    step("bz_n_exec", c_zero(), 1'b1);
    retired(); chk_cnt("bz_n_cnt");

    ir = 16'hD033; a_zero = 1'b1; a_pos = 1'b0;
    step("bp_n_fetch", c_fetch(1'b1), 1'b1);
    step("bp_n_decode", c_decode(), 1'b1);
    step("bp_n_exec", c_zero(), 1'b1);
    retired();
    a_zero = 1'b0; a_pos = 1'b1;
    step("bp_t_fetch", c_fetch(1'b1), 1'b1);
    step("bp_t_decode", c_decode(), 1'b1);
    step("bp_t_exec", c_pc(1'b1, 2'd1), 1'b1);
    retired(); chk_cnt("bp_cnt");
    a_pos = 1'b0;

    ir = 16'hF240;
    step("jal_fetch", c_fetch(1'b1), 1'b1);
    step("jal_decode", c_decode(), 1'b1);
    step("jal_exec", c_jal(), 1'b1);
    retired();
    ir = 16'hE000;
    step("jr_fetch", c_fetch(1'b1), 1'b1);
    step("jr_decode", c_decode(), 1'b1);
    step("jr_exec", c_pc(1'b1, 2'd2), 1'b1);
    retired();
    ir = 16'h7042;
    step("li_fetch", c_fetch(1'b1), 1'b1);
    step("li_decode", c_decode(), 1'b1);
    step("li_exec", c_zero(), 1'b1);
    step("li_wb", c_wb(2'd2), 1'b1);
    retired();
    ir = 16'h6123;
    step("shr_fetch", c_fetch(1'b1), 1'b1);
    step("shr_decode", c_decode(), 1'b1);
    step("shr_exec", c_alu(3'd5), 1'b1);
    step("shr_wb", c_wb(2'd0), 1'b1);
    retired();
    ir = 16'h3000;
    step("and_fetch", c_fetch(1'b1), 1'b1);
    step("and_decode", c_decode(), 1'b1);
    step("and_exec", c_alu(3'd2), 1'b1);
    step("and_wb", c_wb(2'd0), 1'b1);
    retired(); chk_cnt("misc_cnt");

    ir = 16'h9020;
    step("st_fetch", c_fetch(1'b1), 1'b1);
    step("st_decode", c_decode(), 1'b1);
    step("st_exec", c_zero(), 1'b1);
    step("st_mem_wait", c_mem(1'b0), 1'b0);
    step("st_mem_done", c_mem(1'b0), 1'b1);
    retired();
    ir = 16'hA011;
    step("ldr_fetch", c_fetch(1'b1), 1'b1);
    step("ldr_decode", c_decode(), 1'b1);
    step("ldr_exec", c_zero(), 1'b1);
    step("ldr_mem", c_mem(1'b1), 1'b1);
    step("ldr_wb", c_wb(2'd1), 1'b1);
    retired(); chk_cnt("mem_cnt");

    ir = 16'h0000;
    step("hlt_fetch", c_fetch(1'b1), 1'b1);
    step("hlt_decode", c_decode(), 1'b1);
    retired();
    for (int i = 0; i < 20; i++) begin
      ir = 16'($urandom);
      step("halt_park", c_halt(), 1'($urandom_range(0, 1)));
    end
    chk_cnt("halt_cnt");
    rst_n = 1'b0;
    step("halt_reset", c_zero(), 1'b1);
    exp_cnt = 0; chk_cnt("halt_reset_cnt");

    rst_n = 1'b1; ir = 16'hC000; a_zero = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
      repeat (3) @(negedge clk);
      retired();
    end
    chk_cnt("cnt_max");
    repeat (3) @(negedge clk);
    retired(); chk_cnt("cnt_wrap");

    ir = 16'h9055;
    step("str_fetch", c_fetch(1'b1), 1'b1);
    step("str_decode", c_decode(), 1'b1);
    step("str_exec", c_zero(), 1'b1);
    step("str_mem_wait", c_mem(1'b0), 1'b0);
    exp_q.push_back(c_mem(1'b0));
    tag_q.push_back("str_mem_before_rst");
    #1;
    check_ctl();
    rst_n = 1'b0;
    exp_q.push_back(c_zero());
    tag_q.push_back("str_rst_drop");
    #1;
    check_ctl();
    exp_cnt = 0; chk_cnt("str_rst_cnt");
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    step("post_rst_fetch", c_fetch(1'b1), 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
